bpi_cmd_arbiter: RTL and testbench

//  Shares one BPI interface FSM (EXECUTE/BUSY handshake) between two requesters:
//  the auto-load sequencer (AL) and the user/JTAG command path (US).

---
 rtl/bpi_cmd_arbiter.sv | 139 +++++++++++++
 tb/tb_bpi_cmd_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bpi_cmd_arbiter.sv
// Two-requester arbiter (auto-load, user) in front of one BPI interface FSM.
// Optional BUSY-wait timeout enabled by defining BPI_ARB_TIMEOUT_EN.
module bpi_cmd_arbiter
`ifdef BPI_ARB_TIMEOUT_EN
#(
  parameter logic [15:0] TMO_CYCLES = 16'd4095
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        AL_REQ,
  input  logic [22:0] AL_ADDR,
  input  logic [15:0] AL_DATA,
  input  logic [1:0]  AL_OP,
  output logic        AL_ACK,
  input  logic        US_REQ,
  input  logic [22:0] US_ADDR,
  input  logic [15:0] US_DATA,
  input  logic [1:0]  US_OP,
  output logic        US_ACK,
  input  logic        BPI_BUSY,
  output logic        BPI_EXECUTE,
  output logic [22:0] BPI_ADDR,
  output logic [15:0] BPI_DATA,
  output logic        BPI_READ,
  output logic        BPI_WRITE,
  output logic [1:0]  GRANT,
  output logic        ARB_ERR
);

  typedef enum logic [2:0] {StIdle, StLatch, StExec, StWaitHi, StWaitLo, StAck} state_e;

  state_e      state_q;
  logic        last_us_q;
  logic        al_wins;
  logic [22:0] sel_addr;
  logic [15:0] sel_data;
  logic [1:0]  sel_op;
  logic        tmo_hit;

  always_comb begin
    // On a tie the requester that was not served last wins.
    al_wins  = AL_REQ & (~US_REQ | last_us_q);
    sel_addr = GRANT[1] ? US_ADDR : AL_ADDR;
    sel_data = GRANT[1] ? US_DATA : AL_DATA;
    sel_op   = GRANT[1] ? US_OP   : AL_OP;
  end

`ifdef BPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q == StExec) begin
      tmo_cnt_q <= 16'd0;
    end else if ((state_q == StWaitHi) || (state_q == StWaitLo)) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign tmo_hit = (tmo_cnt_q == TMO_CYCLES);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      last_us_q   <= 1'b1;
      AL_ACK      <= 1'b0;
      US_ACK      <= 1'b0;
      BPI_EXECUTE <= 1'b0;
      BPI_ADDR    <= 23'd0;
      BPI_DATA    <= 16'd0;
      BPI_READ    <= 1'b0;
      BPI_WRITE   <= 1'b0;
      GRANT       <= 2'b00;
      ARB_ERR     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (AL_REQ | US_REQ) begin
            GRANT   <= al_wins ? 2'b01 : 2'b10;
            state_q <= StLatch;
          end
        end
        StLatch: begin
          BPI_ADDR  <= sel_addr;
          BPI_DATA  <= sel_data;
          BPI_READ  <= sel_op[1];
          BPI_WRITE <= sel_op[0];
          if (sel_op[1] ^ sel_op[0]) begin
            BPI_EXECUTE <= 1'b1;
            state_q     <= StExec;
          end else begin
            AL_ACK  <= GRANT[0];
            US_ACK  <= GRANT[1];
            ARB_ERR <= 1'b1;
            state_q <= StAck;
          end
        end
        StExec: begin
          BPI_EXECUTE <= 1'b0;
          state_q     <= StWaitHi;
        end
        StWaitHi: begin
          if (tmo_hit) begin
            AL_ACK  <= GRANT[0];
            US_ACK  <= GRANT[1];
            ARB_ERR <= 1'b1;
            state_q <= StAck;
          end else if (BPI_BUSY) begin
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (tmo_hit || !BPI_BUSY) begin
            AL_ACK  <= GRANT[0];
            US_ACK  <= GRANT[1];
            ARB_ERR <= tmo_hit;
            state_q <= StAck;
          end
        end
        StAck: begin
          AL_ACK    <= 1'b0;
          US_ACK    <= 1'b0;
          ARB_ERR   <= 1'b0;
          GRANT     <= 2'b00;
          last_us_q <= GRANT[1];
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bpi_cmd_arbiter.sv
// Self-checking bench for bpi_cmd_arbiter: directed cases plus randomized ops
// compared against a round-robin / latency model.
module tb_bpi_cmd_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AL_REQ, US_REQ, BPI_BUSY;
  logic [22:0] AL_ADDR, US_ADDR;
  logic [15:0] AL_DATA, US_DATA;
  logic [1:0]  AL_OP, US_OP;
  logic        AL_ACK, US_ACK, BPI_EXECUTE, BPI_READ, BPI_WRITE, ARB_ERR;
  logic [22:0] BPI_ADDR;
  logic [15:0] BPI_DATA;
  logic [1:0]  GRANT;

  int checks   = 0;
  int failures = 0;
  int last_us  = 1;  // model: reset leaves US as last served

  always #5 CLK = ~CLK;

`ifdef BPI_ARB_TIMEOUT_EN
  localparam int Tmo = 10;
  bpi_cmd_arbiter #(.TMO_CYCLES(16'd10)) dut (
`else
  bpi_cmd_arbiter dut (
`endif
    .CLK(CLK), .RST(RST),
    .AL_REQ(AL_REQ), .AL_ADDR(AL_ADDR), .AL_DATA(AL_DATA), .AL_OP(AL_OP), .AL_ACK(AL_ACK),
    .US_REQ(US_REQ), .US_ADDR(US_ADDR), .US_DATA(US_DATA), .US_OP(US_OP), .US_ACK(US_ACK),
    .BPI_BUSY(BPI_BUSY), .BPI_EXECUTE(BPI_EXECUTE), .BPI_ADDR(BPI_ADDR), .BPI_DATA(BPI_DATA),
    .BPI_READ(BPI_READ), .BPI_WRITE(BPI_WRITE), .GRANT(GRANT), .ARB_ERR(ARB_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, {30'd0, GRANT}, 32'd0);
    chk({tag, "_exec"}, {31'd0, BPI_EXECUTE}, 32'd0);
    chk({tag, "_al_ack"}, {31'd0, AL_ACK}, 32'd0);
    chk({tag, "_us_ack"}, {31'd0, US_ACK}, 32'd0);
    chk({tag, "_err"}, {31'd0, ARB_ERR}, 32'd0);
  endtask

  task automatic scramble(input logic keep_req_low);
    AL_REQ  = keep_req_low ? 1'b0 : 1'($urandom);
    US_REQ  = keep_req_low ? 1'b0 : 1'($urandom);
    AL_ADDR = 23'($urandom);
    US_ADDR = 23'($urandom);
    AL_DATA = 16'($urandom);
    US_DATA = 16'($urandom);
    AL_OP   = 2'($urandom);
    US_OP   = 2'($urandom);
  endtask

  // Called at a negedge with the DUT idle. BUSY rises d cycles after EXECUTE and
  // stays high l (>=2) cycles; ACK is expected the cycle after the fall is sampled.
  task automatic run_op(input logic al_r, input logic us_r,
                        input logic [22:0] aa, input logic [22:0] ua,
                        input logic [15:0] ad, input logic [15:0] ud,
                        input logic [1:0] ao, input logic [1:0] uo,
                        input int d, input int l, input logic drop_req);
    int          win_us;
    logic [22:0] ea;
    logic [15:0] ed;
    logic [1:0]  eo;
    logic        illegal;
    int          ack_k;
    AL_REQ = al_r; US_REQ = us_r;
    AL_ADDR = aa; US_ADDR = ua; AL_DATA = ad; US_DATA = ud; AL_OP = ao; US_OP = uo;
    win_us  = (al_r && us_r) ? (last_us == 1 ? 0 : 1) : (us_r ? 1 : 0);
    ea      = (win_us == 1) ? ua : aa;
    ed      = (win_us == 1) ? ud : ad;
    eo      = (win_us == 1) ? uo : ao;
    illegal = (eo == 2'b00) || (eo == 2'b11);
    ack_k   = illegal ? 2 : 3 + d + l;
    for (int k = 1; k <= ack_k; k++) begin
      @(negedge CLK);
      chk("grant", {30'd0, GRANT}, (win_us == 1) ? 32'd2 : 32'd1);
      chk("execute", {31'd0, BPI_EXECUTE}, {31'd0, (k == 2) && !illegal});
      chk("al_ack", {31'd0, AL_ACK}, {31'd0, (k == ack_k) && (win_us == 0)});
      chk("us_ack", {31'd0, US_ACK}, {31'd0, (k == ack_k) && (win_us == 1)});
      chk("arb_err", {31'd0, ARB_ERR}, {31'd0, (k == ack_k) && illegal});
      if (k >= 2 && !illegal) begin
        chk("addr", {9'd0, BPI_ADDR}, {9'd0, ea});
        chk("data", {16'd0, BPI_DATA}, {16'd0, ed});
        chk("read", {31'd0, BPI_READ}, {31'd0, eo[1]});
        chk("write", {31'd0, BPI_WRITE}, {31'd0, eo[0]});
      end
      if (k >= 2) scramble(drop_req);
      if (!illegal && k == 2 + d) BPI_BUSY = 1'b1;
      if (!illegal && k == 2 + d + l) BPI_BUSY = 1'b0;
    end
    last_us = win_us;
    @(negedge CLK);
    chk_quiet("post_ack");
    AL_REQ = 1'b0;
    US_REQ = 1'b0;
  endtask

  initial begin
    int          exec_k;
    int          ack_k;
    logic [1:0]  r;
    logic        ack_seen;
    RST = 1'b1; BPI_BUSY = 1'b0;
    AL_REQ = 1'b0; US_REQ = 1'b0;
    AL_ADDR = '0; US_ADDR = '0; AL_DATA = '0; US_DATA = '0; AL_OP = '0; US_OP = '0;
    repeat (3) @(negedge CLK);
    chk_quiet("reset");
    chk("reset_addr", {9'd0, BPI_ADDR}, 32'd0);
    chk("reset_data", {16'd0, BPI_DATA}, 32'd0);
    chk("reset_rw", {30'd0, BPI_READ, BPI_WRITE}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk_quiet("idle");

    // AL read of 7FC000, BUSY high 3 cycles after EXECUTE
    run_op(1'b1, 1'b0, 23'h7FC000, 23'h0, 16'h00A5, 16'h0, 2'b10, 2'b00, 3, 2, 1'b0);

    // Both held: grants must alternate, starting with US after the AL op above
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 1'b1, 23'($urandom), 23'($urandom), 16'($urandom), 16'($urandom),
             2'b01, 2'b10, i % 3, 2 + i % 2, 1'b0);

    // Illegal US op: no EXECUTE, US_ACK with ARB_ERR at n+2
    run_op(1'b0, 1'b1, 23'h0, 23'h12345, 16'h0, 16'hBEEF, 2'b00, 2'b11, 0, 2, 1'b0);

    // AL_REQ dropped after LATCH
    run_op(1'b1, 1'b0, 23'h001234, 23'h0, 16'h5A5A, 16'h0, 2'b01, 2'b00, 1, 3, 1'b1);

    // Randomized traffic, including illegal ops and back-to-back requests
    for (int i = 0; i < 30; i++) begin
      r = 2'($urandom_range(1, 3));
      run_op(r[0], r[1], 23'($urandom), 23'($urandom), 16'($urandom), 16'($urandom),
             2'($urandom), 2'($urandom), $urandom_range(0, 3), $urandom_range(2, 4), 1'b0);
    end

    // Reset in WAIT_LO after AL was served last: the next tie must still go to AL
    run_op(1'b1, 1'b0, 23'h000111, 23'h0, 16'h1111, 16'h0, 2'b10, 2'b00, 0, 2, 1'b0);
    AL_REQ = 1'b1; AL_OP = 2'b01; AL_ADDR = 23'h2222; AL_DATA = 16'h2222;
    @(negedge CLK);
    @(negedge CLK);
    BPI_BUSY = 1'b1;
    AL_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_quiet("mid_reset");
    chk("mid_reset_addr", {9'd0, BPI_ADDR}, 32'd0);
    RST = 1'b0; BPI_BUSY = 1'b0;
    last_us = 1;
    @(negedge CLK);
    chk_quiet("after_reset");
    run_op(1'b1, 1'b1, 23'h0AAAAA, 23'h155555, 16'h1234, 16'h4321, 2'b10, 2'b01, 1, 2, 1'b0);
    chk("tie_after_reset", 32'(last_us), 32'd0);

    // BUSY never rises
    AL_REQ = 1'b1; AL_OP = 2'b10; AL_ADDR = 23'h3333; AL_DATA = 16'h3333; US_REQ = 1'b0;
    exec_k = -1; ack_k = -1;
    for (int k = 1; k <= 40 && ack_k < 0; k++) begin
      @(negedge CLK);
      if (k == 2) AL_REQ = 1'b0;
      if (BPI_EXECUTE === 1'b1 && exec_k < 0) exec_k = k;
      if (AL_ACK === 1'b1) begin
        ack_k = k;
        chk("stall_err", {31'd0, ARB_ERR}, 32'd1);
      end
    end
    chk("stall_exec_at", 32'(exec_k), 32'd2);
`ifdef BPI_ARB_TIMEOUT_EN
    chk("tmo_ack_window",
        {31'd0, (ack_k - exec_k >= Tmo) && (ack_k - exec_k <= Tmo + 3)}, 32'd1);
    last_us = 0;
    @(negedge CLK);
    chk_quiet("tmo_idle");
`else
    chk("no_tmo_ack", 32'(ack_k), 32'hFFFF_FFFF);
    chk("no_tmo_grant", {30'd0, GRANT}, 32'd1);
    BPI_BUSY = 1'b1;
    repeat (2) @(negedge CLK);
    BPI_BUSY = 1'b0;
    ack_seen = 1'b0;
    for (int k = 0; k < 10 && !ack_seen; k++) begin
      @(negedge CLK);
      if (AL_ACK === 1'b1) begin
        ack_seen = 1'b1;
        chk("release_err", {31'd0, ARB_ERR}, 32'd0);
      end
    end
    chk("release_ack", {31'd0, ack_seen}, 32'd1);
    last_us = 0;
    @(negedge CLK);
    chk_quiet("release_idle");
`endif

    // After AL served, a tie goes to US
    run_op(1'b1, 1'b1, 23'h000001, 23'h000002, 16'h0001, 16'h0002, 2'b10, 2'b10, 2, 2, 1'b0);
    chk("final_rr", 32'(last_us), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
